// File: rtl/riscv_pkg.sv
// Shared definitions for the integer register file and writeback stage.
// Holds the writeback source encoding, the default widths and a helper
// that says whether a writeback select code names a real source.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_MUL  = 3'd1,
    WB_LOAD = 3'd2,
    WB_PC4  = 3'd3,
    WB_IMM  = 3'd4
  } wb_sel_e;

  // Codes 5..7 are unassigned; they must neither write nor produce data.
  function automatic logic wb_sel_valid(input logic [2:0] sel);
    return (sel <= 3'd4);
  endfunction

endpackage

// File: rtl/rv_regfile_wb_if.sv
// Bus between the core datapath and the register file / writeback stage.
// master: the core (drives addresses, writeback controls and result sources,
//         receives read data, trace data, instret and the illegal flag).
// slave:  rv_regfile_wb.
interface rv_regfile_wb_if #(
  parameter int XLEN = riscv_pkg::XLEN_DEF,
  parameter int AW   = $clog2(riscv_pkg::NREG_DEF)
);
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   dbg_addr;
  logic            wb_en;
  logic [2:0]      wb_sel;
  logic            retire;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] m_res;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] rv1;
  logic [XLEN-1:0] rv2;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] dbg_data;
  logic [63:0]     instret;
  logic            wb_illegal;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, dbg_addr, wb_en, wb_sel, retire,
           alu_res, m_res, load_data, pc_plus4, imm_u,
    input  rv1, rv2, wb_data, dbg_data, instret, wb_illegal
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, dbg_addr, wb_en, wb_sel, retire,
           alu_res, m_res, load_data, pc_plus4, imm_u,
    output rv1, rv2, wb_data, dbg_data, instret, wb_illegal
  );
endinterface

// File: rtl/rv_wb_mux.sv
// Combinational writeback source selector.
// Ports: wb_sel (wb_sel_e code), the five result sources, wb_data out.
// Undefined select codes yield zero.
module rv_wb_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      wb_sel,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] m_res,
  input  logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] wb_data
);

  always_comb begin
    wb_data = '0;
    case (wb_sel_e'(wb_sel))
      WB_ALU:  wb_data = alu_res;
      WB_MUL:  wb_data = m_res;
      WB_LOAD: wb_data = load_data;
      WB_PC4:  wb_data = pc_plus4;
      WB_IMM:  wb_data = imm_u;
      default: wb_data = '0;
    endcase
  end

endmodule

// File: rtl/rv_regfile_wb.sv
// Integer register file and writeback stage of the single-cycle core.
// Ports: clk, rst_n (async active-low), bus (rv_regfile_wb_if.slave):
//   rs1/rs2/dbg read ports (combinational), rd write port fed by the
//   writeback mux, 64-bit retired-instruction counter, sticky wb_illegal.
// Optional macro REGFILE_BYPASS_EN: forwards the value being written this
// cycle to rv1/rv2/dbg_data when their address matches rd_addr.
module rv_regfile_wb
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input logic          clk,
  input logic          rst_n,
  rv_regfile_wb_if.slave bus
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [63:0]     instret_q, instret_d;
  logic            wb_illegal_q, wb_illegal_d;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rv1, rv2, dbg_data;
  logic            sel_ok;
  logic            we;

  rv_wb_mux #(.XLEN(XLEN)) u_wb_mux (
    .wb_sel    (bus.wb_sel),
    .alu_res   (bus.alu_res),
    .m_res     (bus.m_res),
    .load_data (bus.load_data),
    .pc_plus4  (bus.pc_plus4),
    .imm_u     (bus.imm_u),
    .wb_data   (wb_data)
  );

  assign sel_ok = wb_sel_valid(bus.wb_sel);
  // x0 is never written, so regs_q[0] stays at its reset value of zero.
  assign we = bus.wb_en && sel_ok && (bus.rd_addr != '0) &&
              (int'(bus.rd_addr) < NREG);

  always_comb begin
    rv1      = regs_q[bus.rs1_addr];
    rv2      = regs_q[bus.rs2_addr];
    dbg_data = regs_q[bus.dbg_addr];
`ifdef REGFILE_BYPASS_EN
    if (we && (bus.rs1_addr == bus.rd_addr)) rv1      = wb_data;
    if (we && (bus.rs2_addr == bus.rd_addr)) rv2      = wb_data;
    if (we && (bus.dbg_addr == bus.rd_addr)) dbg_data = wb_data;
`endif
    if (bus.rs1_addr == '0) rv1      = '0;
    if (bus.rs2_addr == '0) rv2      = '0;
    if (bus.dbg_addr == '0) dbg_data = '0;
  end

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[bus.rd_addr] = wb_data;
    instret_d    = instret_q + {63'd0, bus.retire};
    wb_illegal_d = wb_illegal_q | (bus.wb_en & ~sel_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      instret_q    <= '0;
      wb_illegal_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      instret_q    <= instret_d;
      wb_illegal_q <= wb_illegal_d;
    end
  end

  assign bus.rv1        = rv1;
  assign bus.rv2        = rv2;
  assign bus.dbg_data   = dbg_data;
  assign bus.wb_data    = wb_data;
  assign bus.instret    = instret_q;
  assign bus.wb_illegal = wb_illegal_q;

endmodule

// File: tb/tb_rv_regfile_wb.sv
// Directed bench for rv_regfile_wb: reset, write/read, x0, source select,
// illegal select, back-to-back writes and instret wrap/count.
module tb_rv_regfile_wb;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rv_regfile_wb_if #(.XLEN(32), .AW(5)) bus ();

  rv_regfile_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic [31:0] exp_wb;
    logic        writes;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{3'd0, 5'd10, 32'hA1A1_0001, 1'b1};
    vecs[1] = '{3'd1, 5'd11, 32'hB2B2_0002, 1'b1};
    vecs[2] = '{3'd2, 5'd12, 32'hC3C3_0003, 1'b1};
    vecs[3] = '{3'd3, 5'd13, 32'hD4D4_0004, 1'b1};
    vecs[4] = '{3'd4, 5'd14, 32'hE5E5_0005, 1'b1};
    vecs[5] = '{3'd5, 5'd15, 32'h0000_0000, 1'b0};
    vecs[6] = '{3'd6, 5'd16, 32'h0000_0000, 1'b0};
    vecs[7] = '{3'd7, 5'd17, 32'h0000_0000, 1'b0};

    rst_n         = 1'b0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
    bus.rd_addr   = '0;
    bus.dbg_addr  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_sel    = 3'd0;
    bus.retire    = 1'b0;
    bus.alu_res   = '0;
    bus.m_res     = '0;
    bus.load_data = '0;
    bus.pc_plus4  = '0;
    bus.imm_u     = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Preload x1, x2, set the illegal flag and retire three instructions.
    bus.retire = 1'b1;
    bus.wb_en  = 1'b1;
    bus.wb_sel = WB_ALU;
    bus.rd_addr = 5'd1; bus.alu_res = 32'h1111_1111;
    step();
    bus.rd_addr = 5'd2; bus.alu_res = 32'h2222_2222;
    step();
    bus.wb_sel = 3'd6; bus.rd_addr = 5'd3;
    step();
    bus.wb_en = 1'b0; bus.retire = 1'b0; bus.wb_sel = WB_ALU;
    bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd2; bus.dbg_addr = 5'd1;
    #1;
    check("preload_rv1", 64'(bus.rv1), 64'h1111_1111);
    check("preload_rv2", 64'(bus.rv2), 64'h2222_2222);
    check("preload_instret", bus.instret, 64'd3);
    check("preload_illegal", 64'(bus.wb_illegal), 64'd1);

    // Asynchronous reset asserted mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rv1", 64'(bus.rv1), 64'd0);
    check("rst_rv2", 64'(bus.rv2), 64'd0);
    check("rst_dbg", 64'(bus.dbg_data), 64'd0);
    check("rst_instret", bus.instret, 64'd0);
    check("rst_illegal", 64'(bus.wb_illegal), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Write then read; same-cycle read depends on forwarding.
    bus.wb_en = 1'b1; bus.wb_sel = WB_MUL; bus.m_res = 32'hDEAD_BEEF;
    bus.rd_addr = 5'd5; bus.rs1_addr = 5'd5; bus.dbg_addr = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_rv1", 64'(bus.rv1), 64'hDEAD_BEEF);
    check("same_cycle_dbg", 64'(bus.dbg_data), 64'hDEAD_BEEF);
`else
    check("same_cycle_rv1", 64'(bus.rv1), 64'd0);
    check("same_cycle_dbg", 64'(bus.dbg_data), 64'd0);
`endif
    step();
    bus.wb_en = 1'b0;
    #1;
    check("next_cycle_rv1", 64'(bus.rv1), 64'hDEAD_BEEF);

    // x0 stays zero even when targeted.
    bus.wb_en = 1'b1; bus.wb_sel = WB_ALU; bus.alu_res = 32'h1234_5678;
    bus.rd_addr = 5'd0; bus.rs1_addr = 5'd0; bus.dbg_addr = 5'd0;
    #1;
    check("x0_same_cycle", 64'(bus.rv1), 64'd0);
    step();
    bus.wb_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("x0_later_rv1", 64'(bus.rv1), 64'd0);
      check("x0_later_dbg", 64'(bus.dbg_data), 64'd0);
      step();
    end
    check("illegal_clear_before_table", 64'(bus.wb_illegal), 64'd0);

    // Source select table.
    bus.alu_res   = 32'hA1A1_0001;
    bus.m_res     = 32'hB2B2_0002;
    bus.load_data = 32'hC3C3_0003;
    bus.pc_plus4  = 32'hD4D4_0004;
    bus.imm_u     = 32'hE5E5_0005;
    for (int i = 0; i < 8; i++) begin
      bus.wb_en = 1'b1; bus.wb_sel = vecs[i].sel; bus.rd_addr = vecs[i].rd;
      bus.dbg_addr = 5'd0;
      #1;
      check($sformatf("wb_data_sel%0d", vecs[i].sel), 64'(bus.wb_data),
            64'(vecs[i].exp_wb));
      step();
      bus.wb_en = 1'b0; bus.dbg_addr = vecs[i].rd;
      #1;
      check($sformatf("reg_after_sel%0d", vecs[i].sel), 64'(bus.dbg_data),
            vecs[i].writes ? 64'(vecs[i].exp_wb) : 64'd0);
    end
    check("illegal_set", 64'(bus.wb_illegal), 64'd1);
    for (int i = 0; i < 3; i++) step();
    check("illegal_sticky", 64'(bus.wb_illegal), 64'd1);

    // Back-to-back writes to x7.
    bus.wb_en = 1'b1; bus.wb_sel = WB_ALU; bus.rd_addr = 5'd7;
    bus.rs2_addr = 5'd7; bus.dbg_addr = 5'd7;
    bus.alu_res = 32'd1;
    step();
    bus.alu_res = 32'd2;
    step();
    bus.alu_res = 32'd3;
    bus.wb_en = 1'b0;
    #1;
    check("b2b_second_rv2", 64'(bus.rv2), 64'd2);
    bus.wb_en = 1'b1;
    step();
    bus.wb_en = 1'b0;
    #1;
    check("b2b_third_rv2", 64'(bus.rv2), 64'd3);
    check("b2b_third_dbg", 64'(bus.dbg_data), 64'd3);

    // instret wrap and count.
    bus.retire = 1'b0;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    check("instret_forced", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.retire = 1'b1;
    step();
    check("instret_wrap", bus.instret, 64'd0);
    for (int i = 0; i < 10; i++) step();
    bus.retire = 1'b0;
    check("instret_ten", bus.instret, 64'd10);
    step();
    check("instret_hold", bus.instret, 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_regfile_wb.md
Name: rv_regfile_wb

Overview:
- Integer register file and writeback stage of the single-cycle RISC-V core.
- Supplies rv1/rv2 to the R-type and M-type execute units, including the MULDIV unit.
- Selects and commits the cycle's result (ALU, MULDIV, load, PC+4, immediate) to rd.
- Maintains a 64-bit retired-instruction counter and a debug read port.

Parameters:
- XLEN, 32, data width of registers and results.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- AW, $clog2(NREG), register address width.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rd_addr  in  AW  write address.
- wb_en  in  1  instruction writes rd this cycle.
- wb_sel  in  3  writeback source select (wb_sel_e).
- retire  in  1  instruction completes this cycle.
- alu_res  in  XLEN  R/I-type result.
- m_res  in  XLEN  MULDIV result (regdata_R of the M unit).
- load_data  in  XLEN  load data, already sign- or zero-extended.
- pc_plus4  in  XLEN  link value.
- imm_u  in  XLEN  LUI/AUIPC value.
- dbg_addr  in  AW  debug read address.
- rv1  out  XLEN  read data 1.
- rv2  out  XLEN  read data 2.
- wb_data  out  XLEN  selected writeback value, for trace.
- dbg_data  out  XLEN  debug read data.
- instret  out  64  retired-instruction count.
- wb_illegal  out  1  registered flag; set when wb_en is high with an undefined wb_sel.

Behaviour:
- Reset: while rst_n is low, asynchronously clear all registers, instret and wb_illegal to 0. rv1, rv2 and dbg_data therefore read 0. Reset wins over a coincident write. Deassertion takes effect at the next clk edge.
- Reads are combinational with zero latency. Address 0 always returns 0, whatever was written.
- wb_sel_e encoding: 0 WB_ALU, 1 WB_MUL, 2 WB_LOAD, 3 WB_PC4, 4 WB_IMM. Encodings 5–7 are undefined and give wb_data = 0.
- wb_data is a purely combinational mux of the sources selected by wb_sel.
- Write: at the rising edge, if wb_en is high, rd_addr != 0 and wb_sel is valid, the register at rd_addr takes wb_data. The new value is visible on reads from the next cycle.
- wb_en with rd_addr = 0: no state change; instret is still updated per retire.
- wb_en with an undefined wb_sel: no register write; wb_illegal is set at that edge and stays set (sticky) until reset.
- Same-cycle read of rd_addr without the optional feature: the read returns the old value.
- instret: +1 at each edge where retire is high. Wraps from 2^64−1 to 0 with no flag. retire is independent of wb_en (stores and branches retire without writing).
- No stalls and no handshake: one writeback per cycle maximum, as the core is single-cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wb_en is high, rd_addr != 0, wb_sel is valid, and rs1_addr or rs2_addr equals rd_addr, the matching rv output returns wb_data combinationally in the same cycle. dbg_data is bypassed the same way.
- Undefined: no forwarding; reads see the old value.

Decomposition:
- riscv_pkg holds the wb_sel_e enum, XLEN_DEF = 32 and NREG_DEF = 32.
- One sub-module: rv_wb_mux, the combinational source selector, reused by the trace logic.
- The register array, the write logic and instret live in the top module.

Test Plan:
- Reset with registers preloaded: drive rst_n low mid-cycle -> rv1, rv2, dbg_data and instret read 0 immediately; wb_illegal = 0.
- Write and read: wb_en = 1, wb_sel = WB_MUL, m_res = 0xDEADBEEF, rd = 5; next cycle rs1_addr = 5 -> rv1 = 0xDEADBEEF. In the same cycle as the write, rv1 reads the old value 0 without the feature, or 0xDEADBEEF with REGFILE_BYPASS_EN.
- x0 protection: wb_en = 1, rd = 0, alu_res = 0x12345678 -> rv1 for address 0 stays 0 on that cycle and every later one.
- Source select: cycle through wb_sel 0–4, each source carrying a distinct pattern -> wb_data matches each source. wb_sel = 6 with wb_en high -> no write, wb_data = 0, wb_illegal = 1 and sticky.
- instret: force the counter to 0xFFFF_FFFF_FFFF_FFFF and pulse retire -> 0. 10 cycles with retire high and wb_en low -> instret = 10.
- Back-to-back writes: rd = 7 with 1, then 2, then 3 on consecutive cycles -> after the third edge rv2 (rs2 = 7) = 3; dbg_addr = 7 also gives 3.
